// File: rtl/pulse_stretcher_if.sv
// ============================================================================
// Module   : pulse_stretcher_if
// Brief    : Strobe input and stretched-pulse status bundle for pulse_stretcher.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pulse_stretcher_if #(
  parameter int PEND_W = 3
);
  logic              pulse_in;
  logic              level_out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output pulse_in,
    input  level_out,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  pulse_in,
    output level_out,
    output busy,
    output pending,
    output overflow
  );
endinterface

`default_nettype wire

// File: rtl/pulse_stretcher.sv
// ============================================================================
// Module   : pulse_stretcher
// Brief    : Turns one-cycle strobes into fixed-width pulses separated by a
//            guaranteed low gap, queueing strobes that arrive mid-pulse.
//            Optional: PULSE_STRETCHER_RETRIGGER_EN extends the current pulse
//            on strobes seen during the high phase instead of queueing them.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pulse_stretcher #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  wire logic         clock,
  input  wire logic         reset,
  pulse_stretcher_if.slave  bus
);

  localparam int c_MAX_PHASE = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int c_CNT_W     = $clog2(c_MAX_PHASE + 1);

  localparam logic [c_CNT_W-1:0] c_HIGH_LOAD = c_CNT_W'(HIGH_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LOAD  = c_CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0]  c_PEND_MAX  = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [PEND_W-1:0]   r_pending;
  logic                r_level;
  logic                r_overflow;

  logic w_inc;
  logic w_retrig;
  logic w_gap_end;
  logic w_consume;
  logic w_full;

`ifdef PULSE_STRETCHER_RETRIGGER_EN
  assign w_retrig = bus.pulse_in && (r_state == ST_HIGH);
  assign w_inc    = bus.pulse_in && (r_state == ST_GAP);
`else
  assign w_retrig = 1'b0;
  assign w_inc    = bus.pulse_in && (r_state != ST_IDLE);
`endif

  // A strobe on the final gap cycle is queued and consumed on the same edge,
  // so the next pulse starts without passing through IDLE.
  assign w_gap_end = (r_state == ST_GAP) && (r_cnt == '0);
  assign w_consume = w_gap_end && ((r_pending != '0) || w_inc);
  assign w_full    = (r_pending == c_PEND_MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_pending  <= '0;
      r_level    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (w_inc && !w_consume) begin
        if (w_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_pending <= r_pending + 1'b1;
        end
      end else if (!w_inc && w_consume) begin
        r_pending <= r_pending - 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.pulse_in) begin
            r_state <= ST_HIGH;
            r_cnt   <= c_HIGH_LOAD;
            r_level <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (w_retrig) begin
            r_cnt <= c_HIGH_LOAD;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= ST_GAP;
            r_cnt   <= c_GAP_LOAD;
            r_level <= 1'b0;
          end
        end
        ST_GAP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (w_consume) begin
            r_state <= ST_HIGH;
            r_cnt   <= c_HIGH_LOAD;
            r_level <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign bus.level_out = r_level;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.pending   = r_pending;
  assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
// ============================================================================
// Module   : tb_pulse_stretcher
// Brief    : Scoreboard bench for pulse_stretcher (HIGH=4, GAP=2, PEND_W=3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pulse_stretcher;

  localparam int HC = 4;
  localparam int GC = 2;
  localparam int PW = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  pulse_stretcher_if #(.PEND_W(PW)) bus ();

  pulse_stretcher #(
    .HIGH_CYCLES (HC),
    .GAP_CYCLES  (GC),
    .PEND_W      (PW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // cyc = index of the most recent rising edge; a pulse "after edge t" is
  // seen high at the negedge where cyc == t.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int start;
    int len;
  } pulse_t;

  pulse_t exp_q[$];
  int     ovf_q[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  int     base     = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push_pulse(input int start, input int len);
    pulse_t p;
    p.start = start;
    p.len   = len;
    exp_q.push_back(p);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    base = cyc;
  endtask

  task automatic strobe(input int t0, input int n);
    wait_until(t0 - 1);
    bus.pulse_in = 1'b1;
    wait_until(t0 + n - 1);
    bus.pulse_in = 1'b0;
  endtask

  task automatic drained(input string name);
    chk({name, "_pulses_left"}, exp_q.size(), 0);
    chk({name, "_ovf_left"}, ovf_q.size(), 0);
  endtask

  // Monitor: measures every level_out pulse and every overflow flag.
  initial begin : monitor
    bit     in_p;
    int     ps;
    int     pl;
    pulse_t e;
    in_p = 1'b0;
    ps   = 0;
    pl   = 0;
    forever begin
      @(negedge clock);
      if (bus.level_out === 1'b1) begin
        if (!in_p) begin
          in_p = 1'b1;
          ps   = cyc;
          pl   = 0;
        end
        pl++;
      end else if (in_p) begin
        in_p = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse_start", ps, -1);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_start", ps, e.start);
          chk("pulse_len", pl, e.len);
        end
      end
      if (bus.overflow === 1'b1) begin
        if (ovf_q.size() == 0) chk("unexpected_overflow", cyc, -1);
        else chk("overflow_cycle", cyc, ovf_q.pop_front());
      end
    end
  end

  initial begin
    bus.pulse_in = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_level", int'(bus.level_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_pending", int'(bus.pending), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    @(negedge clock);

    // Single strobe: high 4 cycles, busy through the 2-cycle gap.
    do_reset();
    push_pulse(base + 10, HC);
    strobe(base + 10, 1);
    wait_until(base + 15);
    chk("s1_busy_gap", int'(bus.busy), 1);
    chk("s1_pending", int'(bus.pending), 0);
    wait_until(base + 16);
    chk("s1_busy_idle", int'(bus.busy), 0);
    wait_until(base + 25);
    drained("s1");

    // Strobe on the last gap cycle restarts HIGH with no idle cycle.
    do_reset();
    push_pulse(base + 10, HC);
    push_pulse(base + 16, HC);
    strobe(base + 10, 1);
    wait_until(base + 15);
    chk("s4_busy_last_gap", int'(bus.busy), 1);
    bus.pulse_in = 1'b1;
    wait_until(base + 16);
    bus.pulse_in = 1'b0;
    chk("s4_busy_restart", int'(bus.busy), 1);
    chk("s4_pending", int'(bus.pending), 0);
    chk("s4_level_restart", int'(bus.level_out), 1);
    wait_until(base + 30);
    drained("s4");

`ifdef PULSE_STRETCHER_RETRIGGER_EN
    // Retrigger at edge 13 reloads: high continuously after edges 10..16.
    do_reset();
    push_pulse(base + 10, 7);
    strobe(base + 10, 1);
    strobe(base + 13, 1);
    chk("s6_pending", int'(bus.pending), 0);
    wait_until(base + 30);
    drained("s6");
`else
    // Strobes at edges 10,11,12: pulses every HC+GC cycles, pending 1,2,1,0.
    do_reset();
    push_pulse(base + 10, HC);
    push_pulse(base + 16, HC);
    push_pulse(base + 22, HC);
    wait_until(base + 9);
    bus.pulse_in = 1'b1;
    wait_until(base + 11);
    chk("s2_pending_a", int'(bus.pending), 1);
    wait_until(base + 12);
    bus.pulse_in = 1'b0;
    chk("s2_pending_b", int'(bus.pending), 2);
    wait_until(base + 16);
    chk("s2_pending_c", int'(bus.pending), 1);
    wait_until(base + 22);
    chk("s2_pending_d", int'(bus.pending), 0);
    wait_until(base + 27);
    chk("s2_busy_last_gap", int'(bus.busy), 1);
    wait_until(base + 28);
    chk("s2_busy_idle", int'(bus.busy), 0);
    wait_until(base + 35);
    drained("s2");

    // Held high edges 10..19: 1 immediate, 1 net-zero at the edge-16 gap end,
    // queue fills to 7 by edge 18, edge 19 is dropped -> 9 pulses, 1 overflow.
    do_reset();
    for (int k = 0; k < 9; k++) push_pulse(base + 10 + k * (HC + GC), HC);
    ovf_q.push_back(base + 19);
    wait_until(base + 9);
    bus.pulse_in = 1'b1;
    wait_until(base + 18);
    chk("s3_pending_full", int'(bus.pending), 7);
    wait_until(base + 19);
    bus.pulse_in = 1'b0;
    chk("s3_pending_hold", int'(bus.pending), 7);
    wait_until(base + 22);
    chk("s3_pending_drain", int'(bus.pending), 6);
    wait_until(base + 70);
    chk("s3_pending_end", int'(bus.pending), 0);
    drained("s3");

    // Reset mid-HIGH with pending=3 kills the pulse and the queue at once.
    do_reset();
    push_pulse(base + 9, HC);
    strobe(base + 9, 4);
    chk("s5_pending_pre", int'(bus.pending), 3);
    #1 reset = 1'b1;
    #1;
    chk("s5_level_async", int'(bus.level_out), 0);
    chk("s5_busy_async", int'(bus.busy), 0);
    chk("s5_pending_async", int'(bus.pending), 0);
    @(negedge clock);
    reset = 1'b0;
    base = cyc;
    wait_until(base + 30);
    chk("s5_busy_after", int'(bus.busy), 0);
    drained("s5");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
